// File: rtl/montgomery_pkg.sv
// Shared types and constants for the Montgomery exponentiator and its bench.
package montgomery_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SCAN,
    TO_MONT,
    LOOP_A,
    LOOP_B,
    FROM_MONT,
    OUT
  } state_t;

  localparam logic MODE_FAST   = 1'b0;
  localparam logic MODE_LADDER = 1'b1;

  // Accept-to-out_valid cycles for a ladder-mode request.
  function automatic int unsigned mont_lat(input int unsigned w, input int unsigned e);
    return 1 + (2 * e + 2) * (w + 2);
  endfunction

endpackage

// File: rtl/mont_mul_serial.sv
// Radix-2 bit-serial Montgomery multiplier: p = a*b*2^-W mod m.
// done pulses exactly WORD_WIDTH+1 cycles after start.
module mont_mul_serial #(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  input  logic [WORD_WIDTH-1:0] m,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] p
);

  localparam int unsigned AW = WORD_WIDTH + 2;
  localparam int unsigned CW = $clog2(WORD_WIDTH + 1);

  logic [WORD_WIDTH-1:0] a_q, b_q, m_q;
  logic [AW-1:0]         acc_q, add_c, sum_c, half_c;
  logic [WORD_WIDTH-1:0] fin_c;
  logic [CW-1:0]         cnt_q;
  logic                  busy_q;

  // One reduction step per a bit; acc stays below 2m so AW bits never overflow.
  always_comb begin
    add_c  = acc_q + (a_q[0] ? AW'(b_q) : AW'(0));
    sum_c  = add_c[0] ? add_c + AW'(m_q) : add_c;
    half_c = sum_c >> 1;
    fin_c  = WORD_WIDTH'((half_c >= AW'(m_q)) ? half_c - AW'(m_q) : half_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done   <= 1'b0;
      p      <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_q    <= a;
        b_q    <= b;
        m_q    <= m;
        acc_q  <= '0;
        cnt_q  <= CW'(WORD_WIDTH - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        acc_q <= half_c;
        a_q   <= a_q >> 1;
        if (cnt_q == '0) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
          p      <= fin_c;
        end else begin
          cnt_q <= cnt_q - CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/montgomery_exp_ladder.sv
// Modular exponentiation x^e mod m with a fast square-and-multiply mode and a
// constant-time Montgomery ladder mode, valid/ready on both sides.
module montgomery_exp_ladder
  import montgomery_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned E_WIDTH    = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] m,
  input  logic [WORD_WIDTH-1:0] x,
  input  logic [E_WIDTH-1:0]    e,
  input  logic [WORD_WIDTH-1:0] r_mod_m,
  input  logic [WORD_WIDTH-1:0] r2_mod_m,
  input  logic                  const_time,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] exp_result,
  output logic                  err
);

  localparam int unsigned CW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] m_q, x_q, r_q, r2_q;
  logic [E_WIDTH-1:0]    e_q;
  logic                  mode_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] ra_q, ra_d, rb_q, rb_d;
  logic                  wait_q, wait_d;
  logic                  out_valid_d, err_d;
  logic [WORD_WIDTH-1:0] res_d;
  logic                  accept_c, bit_c, ladder_c, last_c;
  logic                  mul_start, mul_done;
  logic [WORD_WIDTH-1:0] op_a, op_b, mul_p;

  assign in_ready = (state_q == IDLE) && !reset;
  assign accept_c = (state_q == IDLE) && in_valid;
  assign bit_c    = e_q[cnt_q];
  assign ladder_c = (mode_q == MODE_LADDER);
  assign last_c   = (cnt_q == '0);

  // ra holds A (fast) or R0 (ladder); rb holds xt (fast) or R1 (ladder).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    res_d     = exp_result;
    err_d     = err;
    mul_start = 1'b0;
    op_a      = x_q;
    op_b      = r2_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          err_d   = 1'b0;
          cnt_d   = CW'(E_WIDTH - 1);
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!m_q[0]) begin
          err_d   = 1'b1;
          res_d   = '0;
          state_d = OUT;
        end else if (ladder_c) begin
          // Ladder issues the to-Montgomery product here so its latency is fixed.
          mul_start = 1'b1;
          state_d   = TO_MONT;
        end else begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (e_q == '0) begin
          ra_d    = r_q;
          state_d = FROM_MONT;
        end else if (bit_c) begin
          state_d = TO_MONT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      TO_MONT: begin
        mul_start = !wait_q;
        if (mul_done) begin
          rb_d = mul_p;
          if (ladder_c) begin
            ra_d    = r_q;
            state_d = LOOP_A;
          end else begin
            ra_d = mul_p;
            if (last_c) state_d = FROM_MONT;
            else begin
              cnt_d   = cnt_q - CW'(1);
              state_d = LOOP_A;
            end
          end
        end
      end
      LOOP_A: begin
        mul_start = !wait_q;
        op_a      = ra_q;
        op_b      = ladder_c ? rb_q : ra_q;
        if (mul_done) begin
          if (ladder_c) begin
            if (bit_c) ra_d = mul_p;
            else       rb_d = mul_p;
            state_d = LOOP_B;
          end else begin
            ra_d = mul_p;
            if (bit_c)       state_d = LOOP_B;
            else if (last_c) state_d = FROM_MONT;
            else             cnt_d   = cnt_q - CW'(1);
          end
        end
      end
      LOOP_B: begin
        mul_start = !wait_q;
        if (ladder_c && bit_c) begin
          op_a = rb_q;
          op_b = rb_q;
        end else begin
          op_a = ra_q;
          op_b = ladder_c ? ra_q : rb_q;
        end
        if (mul_done) begin
          if (ladder_c && bit_c) rb_d = mul_p;
          else                   ra_d = mul_p;
          if (last_c) state_d = FROM_MONT;
          else begin
            cnt_d   = cnt_q - CW'(1);
            state_d = LOOP_A;
          end
        end
      end
      FROM_MONT: begin
        mul_start = !wait_q;
        op_a      = ra_q;
        op_b      = WORD_WIDTH'(1);
        if (mul_done) begin
          res_d   = mul_p;
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    wait_d      = mul_start ? 1'b1 : (mul_done ? 1'b0 : wait_q);
    out_valid_d = (state_d == OUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      m_q        <= '0;
      x_q        <= '0;
      r_q        <= '0;
      r2_q       <= '0;
      e_q        <= '0;
      mode_q     <= MODE_FAST;
      cnt_q      <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      wait_q     <= 1'b0;
      out_valid  <= 1'b0;
      exp_result <= '0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      wait_q     <= wait_d;
      out_valid  <= out_valid_d;
      exp_result <= res_d;
      err        <= err_d;
      if (accept_c) begin
        m_q    <= m;
        x_q    <= x;
        r_q    <= r_mod_m;
        r2_q   <= r2_mod_m;
        e_q    <= e;
        mode_q <= const_time;
      end
    end
  end

  mont_mul_serial #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_mul (
    .clk  (clk),
    .reset(reset),
    .start(mul_start),
    .a    (op_a),
    .b    (op_b),
    .m    (m_q),
    .done (mul_done),
    .p    (mul_p)
  );

endmodule
